// File: rtl/uart_wb_arbiter.sv
// uart_wb_arbiter: round-robin sharing of the UART bus slave port between NM requesters, with transfer timeout
module uart_wb_arbiter #(
  parameter int NM = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NM-1:0]     m_stb,
  input  logic [NM-1:0]     m_we,
  input  logic [2*NM-1:0]   m_addr,
  input  logic [8*NM-1:0]   m_wdata,
  output logic [NM-1:0]     m_ack,
  output logic [NM-1:0]     m_err,
  output logic [7:0]        m_rdata,
  output logic [1:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_we,
  output logic              s_stb,
  output logic              s_clk,
  input  logic [7:0]        s_rdata,
  input  logic              s_ack,
  output logic              busy
);
  localparam int PW = NM > 1 ? $clog2(NM) : 1;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, g, g_n, pick, idx;
  logic found;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] s_addr_n;
  logic [7:0] s_wdata_n, m_rdata_n;
  logic s_we_n, s_stb_n, s_clk_n;
  logic [NM-1:0] m_ack_n, m_err_n;
  logic [1:0] addr_a [NM];
  logic [7:0] data_a [NM];
  for (genvar k = 0; k < NM; k++) begin : g_split
    assign addr_a[k] = m_addr[2*k +: 2];
    assign data_a[k] = m_wdata[8*k +: 8];
  end
  // first requesting index after the last grant, wrapping around
  always_comb begin
    pick = ptr;
    found = 1'b0;
    idx = ptr;
    for (int i = 1; i <= NM; i++) begin
      idx = PW'((int'(ptr) + i) % NM);
      if (!found && m_stb[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  // next-state and registered-output values for one handshake at a time
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    g_n = g;
    cnt_n = cnt;
    s_addr_n = s_addr;
    s_wdata_n = s_wdata;
    s_we_n = s_we;
    s_stb_n = s_stb;
    s_clk_n = s_clk;
    m_ack_n = '0;
    m_err_n = '0;
    m_rdata_n = m_rdata;
    case (state)
      IDLE: if (found) begin
        g_n = pick;
        s_addr_n = addr_a[pick];
        s_wdata_n = data_a[pick];
        s_we_n = m_we[pick];
        s_stb_n = 1'b1;
        s_clk_n = 1'b1;
        cnt_n = '0;
        state_n = ISSUE;
      end
      ISSUE: begin
        cnt_n = cnt + 1'b1;
        if (s_ack) begin
          m_rdata_n = s_rdata;
          m_ack_n[g] = 1'b1;
          s_stb_n = 1'b0;
          s_clk_n = 1'b0;
          state_n = RELEASE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          m_ack_n[g] = 1'b1;
          m_err_n[g] = 1'b1;
          s_stb_n = 1'b0;
          s_clk_n = 1'b0;
          state_n = RELEASE;
        end
      end
      RELEASE: if (!s_ack) begin
        ptr_n = g;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; reset parks the pointer so requester 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= PW'(NM - 1);
      g <= '0;
      cnt <= '0;
      s_addr <= '0;
      s_wdata <= '0;
      s_we <= 1'b0;
      s_stb <= 1'b0;
      s_clk <= 1'b0;
      m_ack <= '0;
      m_err <= '0;
      m_rdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      g <= g_n;
      cnt <= cnt_n;
      s_addr <= s_addr_n;
      s_wdata <= s_wdata_n;
      s_we <= s_we_n;
      s_stb <= s_stb_n;
      s_clk <= s_clk_n;
      m_ack <= m_ack_n;
      m_err <= m_err_n;
      m_rdata <= m_rdata_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_wb_arbiter.sv
// tb_uart_wb_arbiter: scoreboard bench for the round-robin UART bus arbiter
module tb_uart_wb_arbiter;
  logic clk, reset;
  logic [1:0] m_stb, m_we, m_ack, m_err;
  logic [3:0] m_addr;
  logic [15:0] m_wdata;
  logic [7:0] m_rdata, s_wdata, s_rdata;
  logic [1:0] s_addr;
  logic s_we, s_stb, s_clk, s_ack, busy;
  int checks = 0, errors = 0;
  int ack_delay = 0, ack_hold = 0, w = 0, h = 0;
  logic [7:0] rd_value = 8'h00;
  logic [1:0] hold_req = 2'b00;
  typedef struct packed {logic [1:0] a; logic [7:0] d; logic we;} grant_t;
  typedef struct packed {logic [1:0] ack; logic [1:0] err; logic [7:0] rd;} resp_t;
  grant_t gq[$];
  resp_t aq[$];
  logic stb_q = 1'b0;

  uart_wb_arbiter #(.NM(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_stb(s_stb), .s_clk(s_clk),
    .s_rdata(s_rdata), .s_ack(s_ack), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // one clock step; afterwards the UART responder and one-shot requesters react
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (m_ack[i] && !hold_req[i]) m_stb[i] = 1'b0;
    if (reset) begin
      s_ack = 1'b0; w = 0; h = 0;
    end else if (s_stb && !s_ack) begin
      if (ack_delay >= 0 && w >= ack_delay) begin
        s_ack = 1'b1; s_rdata = rd_value; w = 0;
      end else w++;
    end else if (!s_stb && s_ack) begin
      if (h >= ack_hold) begin
        s_ack = 1'b0; h = 0;
      end else h++;
    end else if (!s_stb) w = 0;
  endtask

  task automatic setreq(input int i, input logic we, input logic [1:0] a, input logic [7:0] d);
    m_we[i] = we;
    m_addr[2*i +: 2] = a;
    m_wdata[8*i +: 8] = d;
  endtask

  task automatic push_g(input int i);
    gq.push_back(grant_t'({m_addr[2*i +: 2], m_wdata[8*i +: 8], m_we[i]}));
  endtask

  task automatic push_a(input logic [1:0] a, input logic [1:0] e, input logic [7:0] rd);
    aq.push_back(resp_t'({a, e, rd}));
  endtask

  task automatic wait_acks(input int n, input string name);
    int seen = 0;
    for (int c = 0; c < 200 && seen < n; c++) begin
      tick();
      if (m_ack != 2'b00) seen++;
    end
    if (seen < n) chk({name, "_ack_timeout"}, 32'(seen), 32'(n));
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((busy || s_ack) && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) chk({name, "_idle_timeout"}, 32'(busy), 32'(0));
  endtask

  task automatic wait_stb(input string name);
    int c = 0;
    while (!s_stb && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) chk({name, "_stb_timeout"}, 32'(s_stb), 32'(1));
  endtask

  // monitor: compare every new grant and every completion against the queues
  always @(negedge clk) begin
    if (s_stb && !stb_q) begin
      if (gq.size() == 0) chk("grant_unexpected", 32'({s_addr, s_wdata, s_we}), 32'hFFFF_FFFF);
      else chk("grant", 32'({s_addr, s_wdata, s_we}), 32'(gq.pop_front()));
    end
    if (m_ack != 2'b00) begin
      if (aq.size() == 0) chk("ack_unexpected", 32'({m_ack, m_err, m_rdata}), 32'hFFFF_FFFF);
      else chk("ack", 32'({m_ack, m_err, m_rdata}), 32'(aq.pop_front()));
    end else if (m_err != 2'b00) chk("err_without_ack", 32'(m_err), 32'(0));
    stb_q = s_stb;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    m_stb = 2'b00; m_we = 2'b00; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = 8'h00;
    repeat (3) tick();
    chk("reset_outputs", 32'({m_ack, m_err, m_rdata, s_addr, s_wdata, s_we, s_stb, s_clk, busy}), 32'(0));
    reset = 1'b0;
    tick();
    chk("post_reset_idle", 32'({s_stb, busy}), 32'(0));
    // both request, requester 0 wins first, then requester 1
    rd_value = 8'h11;
    setreq(0, 1'b1, 2'd0, 8'h41);
    setreq(1, 1'b1, 2'd2, 8'h42);
    push_g(0); push_g(1);
    push_a(2'b01, 2'b00, 8'h11); push_a(2'b10, 2'b00, 8'h11);
    m_stb = 2'b11;
    tick();
    chk("t1_stb_latency", 32'({s_stb, s_clk, busy}), 32'b111);
    tick();
    chk("t1_ack0", 32'(m_ack), 32'(2'b01));
    tick();
    chk("t1_ack_single_cycle", 32'(m_ack), 32'(0));
    wait_acks(1, "t1");
    wait_idle("t1");
    // both held: strict alternation 0,1,0,1
    rd_value = 8'h22;
    hold_req = 2'b11;
    setreq(0, 1'b1, 2'd1, 8'hA0);
    setreq(1, 1'b0, 2'd3, 8'hB1);
    for (int i = 0; i < 2; i++) begin
      push_g(0); push_g(1);
      push_a(2'b01, 2'b00, 8'h22); push_a(2'b10, 2'b00, 8'h22);
    end
    m_stb = 2'b11;
    wait_acks(4, "t2");
    m_stb = 2'b00;
    hold_req = 2'b00;
    wait_idle("t2");
    chk("t2_queues_drained", 32'(gq.size() + aq.size()), 32'(0));
    // read from requester 1 returns UART data
    rd_value = 8'h5A;
    setreq(1, 1'b0, 2'd1, 8'h00);
    push_g(1);
    push_a(2'b10, 2'b00, 8'h5A);
    m_stb = 2'b10;
    wait_acks(1, "t3");
    wait_idle("t3");
    // no s_ack ever: abort after exactly 8 cycles, read data unchanged
    ack_delay = -1;
    setreq(0, 1'b1, 2'd3, 8'hC3);
    push_g(0);
    push_a(2'b01, 2'b01, 8'h5A);
    m_stb = 2'b01;
    wait_stb("t4");
    k = 0;
    while (m_ack == 2'b00 && k < 30) begin
      tick();
      k++;
    end
    chk("t4_timeout_latency", 32'(k), 32'(8));
    tick();
    chk("t4_idle_after_abort", 32'({busy, s_stb}), 32'(0));
    // s_ack held after the transfer keeps the arbiter in release
    ack_delay = 1;
    ack_hold = 5;
    rd_value = 8'h77;
    setreq(0, 1'b1, 2'd2, 8'h10);
    setreq(1, 1'b1, 2'd0, 8'h20);
    push_g(1); push_g(0);
    push_a(2'b10, 2'b00, 8'h77); push_a(2'b01, 2'b00, 8'h77);
    m_stb = 2'b11;
    wait_acks(1, "t5");
    k = 0;
    while (s_ack && k < 20) begin
      chk("t5_hold_release", 32'({s_stb, busy}), 32'b01);
      tick();
      k++;
    end
    chk("t5_ack_hold_cycles", 32'(k), 32'(5));
    ack_hold = 0;
    wait_acks(1, "t5b");
    wait_idle("t5");
    // reset in the middle of a transfer
    ack_delay = -1;
    setreq(1, 1'b0, 2'd1, 8'h00);
    push_g(1);
    m_stb = 2'b10;
    wait_stb("t6");
    tick();
    tick();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_reset", 32'({m_ack, m_err, m_rdata, s_addr, s_wdata, s_we, s_stb, s_clk, busy}), 32'(0));
    setreq(0, 1'b1, 2'd3, 8'h55);
    setreq(1, 1'b1, 2'd1, 8'h66);
    m_stb = 2'b11;
    tick();
    tick();
    ack_delay = 0;
    rd_value = 8'h99;
    push_g(0); push_g(1);
    push_a(2'b01, 2'b00, 8'h99); push_a(2'b10, 2'b00, 8'h99);
    reset = 1'b0;
    wait_acks(2, "t6");
    wait_idle("t6");
    repeat (2) tick();
    chk("end_grant_queue", 32'(gq.size()), 32'(0));
    chk("end_ack_queue", 32'(aq.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
